// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake,
// two-entry skid buffer, flush-to-bubble and a stall counter.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 142,
  parameter int CTRL_W = 7,
  parameter logic [CTRL_W-1:0] CTRL_NOP = 7'h60,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic              in_xfer;
  logic              out_xfer;

  // Handshakes and presented outputs come straight from held state.
  always_comb begin
    in_ready  = !s_valid;
    in_xfer   = in_valid & !s_valid;
    out_xfer  = m_valid & out_ready;
    out_valid = m_valid;
    out_data  = m_data;
    out_ctrl  = m_valid ? m_ctrl : CTRL_NOP;
  end

  // Main/skid entry update: fill main first, spill into skid on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
      m_ctrl  <= CTRL_NOP;
      s_ctrl  <= CTRL_NOP;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_ctrl  <= CTRL_NOP;
      s_ctrl  <= CTRL_NOP;
    end else if (!m_valid) begin
      if (in_xfer) begin
        m_valid <= 1'b1;
        m_data  <= in_data;
        m_ctrl  <= in_ctrl;
      end
    end else if (out_xfer) begin
      if (s_valid) begin
        m_data  <= s_data;
        m_ctrl  <= s_ctrl;
        s_valid <= 1'b0;
      end else if (in_xfer) begin
        m_data  <= in_data;
        m_ctrl  <= in_ctrl;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      s_valid <= 1'b1;
      s_data  <= in_data;
      s_ctrl  <= in_ctrl;
    end
  end

  // Saturating count of cycles where downstream back-pressures us.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (m_valid && !out_ready && !flush
                 && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg with a scoreboard
// monitor checking order, payload and hold-under-stall.
module tb_pipe_stage_skid_reg;

  localparam int DW = 142;
  localparam int CW = 7;
  localparam int NW = 4;
  localparam logic [CW-1:0] NOP = 7'h60;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [DW+CW-1:0] sb[$];

  pipe_stage_skid_reg #(
    .DATA_W(DW), .CTRL_W(CW),
    .CTRL_NOP(NOP), .CNT_W(NW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [191:0] act,
                     logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [DW-1:0] d,
                       logic [CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  // Scoreboard monitor: pops on output transfer, records
  // accepted inputs, and checks outputs hold while stalled.
  logic          hold_prev = 1'b0;
  logic [DW-1:0] pd;
  logic [CW-1:0] pc;
  always @(negedge clk) begin
    logic [DW+CW-1:0] e;
    if (hold_prev) begin
      chk("hold_valid", 192'(out_valid), 192'(1));
      chk("hold_data", 192'(out_data), 192'(pd));
      chk("hold_ctrl", 192'(out_ctrl), 192'(pc));
    end
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected none",
                   out_data);
        end else begin
          e = sb.pop_front();
          chk("sb_data", 192'(out_data), 192'(e[DW-1:0]));
          chk("sb_ctrl", 192'(out_ctrl), 192'(e[DW+CW-1:DW]));
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready)
        sb.push_back({in_ctrl, in_data});
    end
    hold_prev = out_valid && !out_ready && !flush && !reset;
    pd = out_data;
    pc = out_ctrl;
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0);
    step();
    step();
    reset = 1'b0;
    chk("rst_out_valid", 192'(out_valid), 192'(0));
    chk("rst_out_ctrl", 192'(out_ctrl), 192'(7'h60));
    chk("rst_out_data", 192'(out_data), 192'(0));
    chk("rst_in_ready", 192'(in_ready), 192'(1));
    chk("rst_stall_cnt", 192'(stall_cnt), 192'(0));

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, DW'(i), CW'(i));
      step();
      chk("stream_valid", 192'(out_valid), 192'(1));
      chk("stream_data", 192'(out_data), 192'(i));
      chk("stream_ready", 192'(in_ready), 192'(1));
    end
    drive(1'b0, '0, '0);
    step();
    chk("drain_valid", 192'(out_valid), 192'(0));
    chk("drain_ctrl", 192'(out_ctrl), 192'(7'h60));

    // skid fill
    out_ready = 1'b0;
    drive(1'b1, DW'('h11), 7'h01);
    step();
    chk("skA_cnt", 192'(stall_cnt), 192'(0));
    drive(1'b1, DW'('h22), 7'h02);
    step();
    chk("skB_data", 192'(out_data), 192'('h11));
    chk("skB_ready", 192'(in_ready), 192'(0));
    chk("skB_cnt", 192'(stall_cnt), 192'(1));
    drive(1'b0, '0, '0);
    step();
    chk("sk_cnt2", 192'(stall_cnt), 192'(2));
    step();
    chk("sk_cnt3", 192'(stall_cnt), 192'(3));
    out_ready = 1'b1;
    step();
    chk("skr_data", 192'(out_data), 192'('h22));
    chk("skr_ready", 192'(in_ready), 192'(1));
    chk("skr_cnt", 192'(stall_cnt), 192'(3));
    step();
    chk("skr_empty", 192'(out_valid), 192'(0));

    // flush with skid full and C offered
    out_ready = 1'b0;
    drive(1'b1, DW'('h11), 7'h01);
    step();
    drive(1'b1, DW'('h22), 7'h02);
    step();
    chk("fl_cnt_pre", 192'(stall_cnt), 192'(4));
    drive(1'b1, DW'('h33), 7'h03);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl_valid", 192'(out_valid), 192'(0));
    chk("fl_ctrl", 192'(out_ctrl), 192'(7'h60));
    chk("fl_ready", 192'(in_ready), 192'(1));
    chk("fl_cnt", 192'(stall_cnt), 192'(4));

    // flush discarding an accepted same-cycle input
    drive(1'b1, DW'('h44), 7'h04);
    step();
    drive(1'b1, DW'('h55), 7'h05);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl2_valid", 192'(out_valid), 192'(0));
    chk("fl2_ready", 192'(in_ready), 192'(1));
    out_ready = 1'b1;
    step();
    step();
    chk("fl2_nothing", 192'(out_valid), 192'(0));
    chk("fl2_cnt", 192'(stall_cnt), 192'(4));

    // saturation
    out_ready = 1'b0;
    drive(1'b1, DW'('h66), 7'h06);
    step();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", 192'(stall_cnt), 192'(15));
    step();
    step();
    chk("sat_hold", 192'(stall_cnt), 192'(15));
    chk("sat_data", 192'(out_data), 192'('h66));

    // reset mid-stall with skid full
    drive(1'b1, DW'('h77), 7'h07);
    step();
    chk("mr_ready", 192'(in_ready), 192'(0));
    drive(1'b0, '0, '0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_valid", 192'(out_valid), 192'(0));
    chk("mr_data", 192'(out_data), 192'(0));
    chk("mr_ctrl", 192'(out_ctrl), 192'(7'h60));
    chk("mr_in_ready", 192'(in_ready), 192'(1));
    chk("mr_cnt", 192'(stall_cnt), 192'(0));
    out_ready = 1'b1;
    drive(1'b1, DW'('h88), 7'h08);
    step();
    drive(1'b0, '0, '0);
    chk("mr_new_valid", 192'(out_valid), 192'(1));
    chk("mr_new_data", 192'(out_data), 192'('h88));
    chk("mr_new_ctrl", 192'(out_ctrl), 192'(7'h08));
    step();
    step();
    chk("sb_left", 192'(sb.size()), 192'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
